// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end that shares one external 8x8 signed
// sequential multiplier among NREQ requesters.
// Sequence: accept one request, pulse start, wait for the multiplier, then
// hold the response until it is taken. Only one operation is in flight.
// Optional feature: define MULT_ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT cycles. On expiry the response carries rsp_err=1 and a zero product.
module mult_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                mul_start,
    output logic [7:0]          mul_a,
    output logic [7:0]          mul_b,
    input  logic [15:0]         mul_product,
    input  logic                mul_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [15:0]         rsp_product,
    output logic                rsp_err,
    output logic                busy
);

    localparam int unsigned OPND_W  = 8;
    localparam int unsigned PROD_W  = 16;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned PAD_W   = MAX_REQ * OPND_W;
    // An illegal parameter set never grants, so the problem shows up at once in simulation
    localparam bit CFG_OK = (NREQ >= 2) && (NREQ <= MAX_REQ) &&
                            ((32'd1 << ID_W) >= NREQ) && (TIMEOUT >= 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [OPND_W-1:0]   a_q, a_d;
    logic [OPND_W-1:0]   b_q, b_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic                first_q, first_d;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    logic [MAX_REQ-1:0]  valid_pad;
    logic [PAD_W-1:0]    a_pad, b_pad;
    logic [SEL_W-1:0]    grant_sel;
    logic                grant_found;
    logic                take;
    logic [NREQ-1:0]     grant_oh;
    int unsigned         cand;

    // Requester vectors padded to the maximum width so the grant index is fixed-size
    assign valid_pad = MAX_REQ'(req_valid);
    assign a_pad     = PAD_W'(req_a);
    assign b_pad     = PAD_W'(req_b);

    // Cyclic search for the first valid requester at or after ptr
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = '0;
        cand        = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr_q) + k) % NREQ;
            if (!grant_found && valid_pad[SEL_W'(cand)]) begin
                grant_found = 1'b1;
                grant_sel   = SEL_W'(cand);
            end
        end
    end

    assign take      = grant_found && CFG_OK;
    assign grant_oh  = NREQ'(8'b1 << grant_sel);
    assign req_ready = (state_q == ST_IDLE && take && !rst) ? grant_oh : '0;

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        first_d = first_q;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    a_d     = a_pad[{grant_sel, 3'b000} +: OPND_W];
                    b_d     = b_pad[{grant_sel, 3'b000} +: OPND_W];
                    id_d    = ID_W'(grant_sel);
                    ptr_d   = ID_W'((32'(grant_sel) + 32'd1) % NREQ);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                first_d = 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The first WAIT cycle may still see a done flag left over from an earlier run
                first_d = 1'b0;
                if (!first_q && mul_ready) begin
                    prod_d  = mul_product;
`ifdef MULT_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = ST_RESP;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            first_q <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            first_q <= first_d;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign mul_start   = (state_q == ST_START);
    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_id      = id_q;
    assign rsp_product = prod_q;
    assign busy        = (state_q != ST_IDLE);

`ifdef MULT_ARB_TIMEOUT_EN
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule
